vga_sync_decoder: RTL and testbench

//   Receive-side counterpart of the VGA timing generator. Watches hsync, vsync and rgb
//   as driven to the VGA port. Recovers pixel coordinates and video_on. Locks to the

---
 rtl/vga_sync_decoder.sv | 162 ++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// VGA receive-side monitor: recovers x/y, video_on and frame lock from hsync/vsync/rgb.
// Optional per-frame CRC-16-CCITT of active pixels on frame_crc when VGA_DEC_CRC_EN is defined.
module vga_sync_decoder #(
  parameter int   H_DISPLAY = 640,
  parameter int   H_FRONT   = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BACK    = 48,
  parameter int   V_DISPLAY = 480,
  parameter int   V_FRONT   = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BACK    = 33,
  parameter logic SYNC_POL  = 1'b0
) (
  input  logic        clk_100MHz,
  input  logic        reset_n,
  input  logic        p_tick,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [11:0] rgb_in,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        video_on,
  output logic [11:0] pix_rgb,
  output logic        frame_start,
  output logic        locked,
  output logic [7:0]  err_count
`ifdef VGA_DEC_CRC_EN
  ,
  output logic [15:0] frame_crc
`endif
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS_POS = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] VS_POS = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] H_ACT  = 10'(H_DISPLAY);
  localparam logic [9:0] V_ACT  = 10'(V_DISPLAY);

  typedef enum logic [1:0] {HUNT, HALIGN, LOCKED} state_t;

  state_t     state_reg;
  logic       hs_reg, vs_reg;
  logic       hs_arm_reg, vs_arm_reg;
  logic [9:0] h_reg, v_reg;
  logic [9:0] h_nxt, v_nxt;
  logic       hs_act, vs_act, h_edge, v_edge;
  logic       h_ok, v_ok, drop, stay_locked, pix_active, pix_first;

  // An edge needs a genuinely observed deasserted sample first, so a sync held
  // asserted through reset is not mistaken for a fresh pulse.
  assign hs_act = (hsync == SYNC_POL);
  assign vs_act = (vsync == SYNC_POL);
  assign h_edge = hs_act && (hs_reg != SYNC_POL) && hs_arm_reg;
  assign v_edge = vs_act && (vs_reg != SYNC_POL) && vs_arm_reg;

  assign h_nxt = (h_reg == H_LAST) ? 10'd0 : h_reg + 10'd1;
  assign v_nxt = (h_reg != H_LAST) ? v_reg : ((v_reg == V_LAST) ? 10'd0 : v_reg + 10'd1);

  assign h_ok        = (h_nxt == HS_POS);
  assign v_ok        = h_ok && (v_nxt == VS_POS);
  assign drop        = (state_reg == LOCKED) && ((h_edge && !h_ok) || (v_edge && !v_ok));
  assign stay_locked = (state_reg == LOCKED) && !drop;
  assign pix_active  = stay_locked && (h_nxt < H_ACT) && (v_nxt < V_ACT);
  assign pix_first   = stay_locked && (h_nxt == 10'd0) && (v_nxt == 10'd0);

  assign x = h_reg;
  assign y = v_reg;

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= HUNT;
      hs_reg      <= ~SYNC_POL;
      vs_reg      <= ~SYNC_POL;
      hs_arm_reg  <= 1'b0;
      vs_arm_reg  <= 1'b0;
      h_reg       <= 10'd0;
      v_reg       <= 10'd0;
      pix_rgb     <= 12'd0;
      video_on    <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      err_count   <= 8'd0;
    end else begin
      frame_start <= 1'b0;
      if (p_tick) begin
        hs_reg      <= hsync;
        vs_reg      <= vsync;
        hs_arm_reg  <= hs_arm_reg | ~hs_act;
        vs_arm_reg  <= vs_arm_reg | ~vs_act;
        pix_rgb     <= rgb_in;
        h_reg       <= h_nxt;
        v_reg       <= v_nxt;
        video_on    <= pix_active;
        frame_start <= pix_first;
        case (state_reg)
          HUNT: begin
            if (h_edge) begin
              h_reg     <= HS_POS;
              state_reg <= HALIGN;
            end
          end
          HALIGN: begin
            // A misplaced h edge wins over any coincident v edge.
            if (h_edge) begin
              if (!h_ok) begin
                h_reg <= HS_POS;
              end else if (v_edge) begin
                v_reg     <= VS_POS;
                state_reg <= LOCKED;
                locked    <= 1'b1;
              end
            end
          end
          LOCKED: begin
            if (drop) begin
              state_reg <= HUNT;
              locked    <= 1'b0;
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
          end
          default: state_reg <= HUNT;
        endcase
      end
    end
  end

`ifdef VGA_DEC_CRC_EN
  logic [15:0] crc_acc_reg;

  function automatic logic [15:0] crc_px(input logic [15:0] crc, input logic [11:0] pix);
    logic [15:0] r;
    logic [15:0] d;
    r = crc;
    d = {4'h0, pix};
    for (int i = 15; i >= 0; i--) begin
      r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
    end
    return r;
  endfunction

  // Pixel (0,0) opens the new frame's accumulation on the same tick the old total is latched.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      crc_acc_reg <= 16'hFFFF;
      frame_crc   <= 16'h0000;
    end else if (p_tick) begin
      if (!stay_locked) begin
        crc_acc_reg <= 16'hFFFF;
      end else if (pix_first) begin
        frame_crc   <= crc_acc_reg;
        crc_acc_reg <= crc_px(16'hFFFF, rgb_in);
      end else if (pix_active) begin
        crc_acc_reg <= crc_px(crc_acc_reg, rgb_in);
      end
    end
  end
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder with a reduced 16x12 raster so whole frames stay short.
// Expected outputs come from a raster-position model anchored on sync edges.
module tb_vga_sync_decoder;

  localparam int HD = 8, HF = 2, HSW = 3, HB = 3;
  localparam int VD = 6, VF = 2, VSW = 2, VB = 2;
  localparam int HT = HD + HF + HSW + HB;       // 16
  localparam int VT = VD + VF + VSW + VB;       // 12
  localparam int HSP = HD + HF;                 // 10
  localparam int VSP = VD + VF;                 // 8
  localparam int FT = HT * VT;                  // 192
  localparam int LOCK_POS = VSP * HT + HSP;     // 138
  localparam bit POL = 1'b0;

  logic        clk_100MHz = 1'b0;
  logic        reset_n = 1'b0;
  logic        p_tick = 1'b0;
  logic        hsync = 1'b0;
  logic        vsync = 1'b0;
  logic [11:0] rgb_in = 12'h000;
  logic [9:0]  x, y;
  logic        video_on, frame_start, locked;
  logic [11:0] pix_rgb;
  logic [7:0]  err_count;
`ifdef VGA_DEC_CRC_EN
  logic [15:0] frame_crc;
`endif

  vga_sync_decoder #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
    .SYNC_POL(POL)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .reset_n    (reset_n),
    .p_tick     (p_tick),
    .hsync      (hsync),
    .vsync      (vsync),
    .rgb_in     (rgb_in),
    .x          (x),
    .y          (y),
    .video_on   (video_on),
    .pix_rgb    (pix_rgb),
    .frame_start(frame_start),
    .locked     (locked),
    .err_count  (err_count)
`ifdef VGA_DEC_CRC_EN
    ,
    .frame_crc  (frame_crc)
`endif
  );

  always #5 clk_100MHz = ~clk_100MHz;

  int tests = 0;
  int fails = 0;

  // Model state: 0 hunt, 1 h-aligned, 2 locked; positions derived from sample index anchors.
  int m_st, m_n, h_anchor, f_anchor, m_err, fs_last, fs_count;
  bit hs_last, vs_last;
  logic [15:0] m_acc, m_crc;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic [11:0] pix);
    logic [15:0] r;
    logic [15:0] d;
    r = crc;
    d = {4'h0, pix};
    for (int i = 15; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  task automatic model_step(input bit hs_a, input bit vs_a, input logic [11:0] c);
    bit he, ve, e_lock, e_von, e_fs;
    int pos, ex, ey;
    he = hs_a && !hs_last;
    ve = vs_a && !vs_last;
    hs_last = hs_a;
    vs_last = vs_a;
    pos = 0;
    if (m_st == 0) begin
      if (he) begin m_st = 1; h_anchor = m_n; end
    end else if (m_st == 1) begin
      if (he) begin
        if ((HSP + m_n - h_anchor) % HT != HSP) h_anchor = m_n;
        else if (ve) begin m_st = 2; f_anchor = m_n; end
      end
    end else begin
      pos = (LOCK_POS + m_n - f_anchor) % FT;
      if ((he && (pos % HT) != HSP) || (ve && pos != LOCK_POS)) begin
        m_st = 0;
        fs_last = -1;
        if (m_err < 255) m_err++;
      end
    end
    e_lock = (m_st == 2);
    pos = (LOCK_POS + m_n - f_anchor) % FT;
    ex = pos % HT;
    ey = pos / HT;
    e_von = e_lock && ex < HD && ey < VD;
    e_fs  = e_lock && ex == 0 && ey == 0;
    chk("locked", int'(locked), int'(e_lock));
    chk("video_on", int'(video_on), int'(e_von));
    chk("frame_start", int'(frame_start), int'(e_fs));
    chk("pix_rgb", int'(pix_rgb), int'(c));
    chk("err_count", int'(err_count), m_err);
    if (e_lock) begin
      chk("x", int'(x), ex);
      chk("y", int'(y), ey);
    end
    if (!e_lock) m_acc = 16'hFFFF;
    else if (e_fs) begin m_crc = m_acc; m_acc = crc_step(16'hFFFF, c); end
    else if (e_von) m_acc = crc_step(m_acc, c);
`ifdef VGA_DEC_CRC_EN
    chk("frame_crc", int'(frame_crc), int'(m_crc));
`endif
    if (frame_start) begin
      fs_count++;
      if (fs_last >= 0) chk("fs_gap", m_n - fs_last, 192);
      fs_last = m_n;
    end
    m_n++;
  endtask

  // One pixel: p_tick high for one clock, then three idle clocks.
  task automatic px(input bit hs_a, input bit vs_a, input logic [11:0] c);
    @(negedge clk_100MHz);
    p_tick = 1'b1;
    hsync  = hs_a ? POL : ~POL;
    vsync  = vs_a ? POL : ~POL;
    rgb_in = c;
    @(posedge clk_100MHz);
    #1;
    model_step(hs_a, vs_a, c);
    @(negedge clk_100MHz);
    p_tick = 1'b0;
    @(posedge clk_100MHz);
    #1;
    chk("fs_clear", int'(frame_start), 0);
    repeat (2) @(posedge clk_100MHz);
  endtask

  // Full raster from (0,0); err_line moves that line's hsync edge one pixel early.
  task automatic frame(input int err_line, input bit zero_rgb, input int flip_h, input bit lit);
    for (int v = 0; v < VT; v++) begin
      for (int h = 0; h < HT; h++) begin
        int p;
        bit hs_a, vs_a;
        logic [11:0] c;
        p = v * HT + h;
        hs_a = (h >= HSP && h < HSP + HSW) || (v == err_line && h == HSP - 1);
        vs_a = (p >= LOCK_POS) && (p < LOCK_POS + VSW * HT);
        c = zero_rgb ? 12'h000 : 12'(p * 37 + 5);
        if (h == flip_h && v == 2) c = 12'h001;
        if (lit && h == HD - 1 && v == VD - 1) c = 12'hABC;
        px(hs_a, vs_a, c);
        if (lit && h == HD - 1 && v == VD - 1) begin
          chk("lit_x_last", int'(x), 7);
          chk("lit_y_last", int'(y), 5);
          chk("lit_rgb_last", int'(pix_rgb), 12'hABC);
          chk("lit_von_last", int'(video_on), 1);
        end
        if (lit && h == HD && v == VD - 1) begin
          chk("lit_x_porch", int'(x), 8);
          chk("lit_von_porch", int'(video_on), 0);
        end
      end
    end
  endtask

  function automatic logic [15:0] golden_frame(input int flip_h);
    logic [15:0] acc;
    acc = 16'hFFFF;
    for (int v = 0; v < VD; v++)
      for (int h = 0; h < HD; h++)
        acc = crc_step(acc, (h == flip_h && v == 2) ? 12'h001 : 12'h000);
    return acc;
  endfunction

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    $display("[TB] reset: inputs toggling under reset_n=0");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_100MHz);
      p_tick = i[0];
      hsync  = ~hsync;
      vsync  = i[1];
      rgb_in = 12'($urandom);
      @(posedge clk_100MHz);
      #1;
      chk("rst_x", int'(x), 0);
      chk("rst_y", int'(y), 0);
      chk("rst_video_on", int'(video_on), 0);
      chk("rst_pix_rgb", int'(pix_rgb), 0);
      chk("rst_frame_start", int'(frame_start), 0);
      chk("rst_locked", int'(locked), 0);
      chk("rst_err_count", int'(err_count), 0);
    end
    @(negedge clk_100MHz);
    p_tick = 1'b0;
    hsync = POL;
    vsync = POL;
    reset_n = 1'b1;
    m_st = 0; m_n = 0; h_anchor = 0; f_anchor = 0; m_err = 0;
    fs_last = -1; fs_count = 0;
    hs_last = 1'b1; vs_last = 1'b1;
    m_acc = 16'hFFFF; m_crc = 16'h0000;

    $display("[TB] syncs held asserted out of reset");
    repeat (3) px(1'b1, 1'b1, 12'h000);

    $display("[TB] lock: three frames of standard timing");
    frame(-1, 1'b0, -1, 1'b0);
    chk("lit_locked_f1", int'(locked), 1);
    frame(-1, 1'b0, -1, 1'b0);
    frame(-1, 1'b0, -1, 1'b1);
    chk("lit_fs_count", fs_count, 2);

    $display("[TB] h error: line 2 hsync one pixel early");
    frame(2, 1'b0, -1, 1'b0);
    chk("lit_err_one", int'(err_count), 1);
    chk("lit_relocked", int'(locked), 1);
    frame(-1, 1'b0, -1, 1'b0);

`ifdef VGA_DEC_CRC_EN
    $display("[TB] crc: zero frames and one flipped pixel");
    frame(-1, 1'b1, -1, 1'b0);
    frame(-1, 1'b1, -1, 1'b0);
    chk("crc_zero_frame", int'(frame_crc), int'(golden_frame(-1)));
    frame(-1, 1'b1, 3, 1'b0);
    frame(-1, 1'b1, -1, 1'b0);
    chk("crc_flip_frame", int'(frame_crc), int'(golden_frame(3)));
    chk("crc_flip_differs", int'(frame_crc != golden_frame(-1)), 1);
`endif

    $display("[TB] saturation: 300 forced lock losses");
    for (int k = 0; k < 300; k++) begin
      px(1'b1, 1'b0, 12'h000);
      repeat (HT - 1) px(1'b0, 1'b0, 12'h000);
      px(1'b1, 1'b1, 12'h000);
      px(1'b0, 1'b0, 12'h000);
      px(1'b1, 1'b0, 12'h000);
      px(1'b0, 1'b0, 12'h000);
    end
    chk("lit_err_sat", int'(err_count), 255);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
